// File: rtl/encoder_angle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : encoder_angle_ctrl_if
// Brief    : Step-pulse / angle-output bundle between the encoder decoder,
//            the angle controller and the servo/display consumers.
// Revision : 1.0 - initial release
// ============================================================================
interface encoder_angle_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cw;
    logic             ccw;
    logic             auto_en;
    logic [WIDTH-1:0] angle;
    logic             angle_upd;
    logic             sweep_dir;
    logic             at_limit;

    modport master (
        output cw, ccw, auto_en,
        input  angle, angle_upd, sweep_dir, at_limit
    );

    modport slave (
        input  cw, ccw, auto_en,
        output angle, angle_upd, sweep_dir, at_limit
    );
endinterface
`default_nettype wire

// File: rtl/encoder_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : encoder_angle_ctrl
// Brief    : Commanded pointing angle from encoder steps (manual) or a
//            saturating back-and-forth ramp (auto-sweep).
// Revision : 1.0 - initial release
// ============================================================================
module encoder_angle_ctrl #(
    parameter int WIDTH       = 8,
    parameter int MIN_ANGLE   = 0,
    parameter int MAX_ANGLE   = 180,
    parameter int STEP        = 1,
    parameter int RESET_ANGLE = 90,
    parameter int SWEEP_DIV   = 500000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    encoder_angle_ctrl_if.slave bus
);

    localparam int              c_CNT_W    = $clog2(SWEEP_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SWEEP_DIV - 1);
    localparam logic [WIDTH-1:0]   c_MIN      = WIDTH'(MIN_ANGLE);
    localparam logic [WIDTH-1:0]   c_MAX      = WIDTH'(MAX_ANGLE);
    localparam logic [WIDTH-1:0]   c_STEP     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   c_RESET    = WIDTH'(RESET_ANGLE);
    localparam logic [WIDTH:0]     c_MAX_X    = (WIDTH+1)'(MAX_ANGLE);
    localparam logic [WIDTH:0]     c_STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]     c_DN_FLOOR = (WIDTH+1)'(MIN_ANGLE + STEP);

    typedef enum logic [1:0] {
        S_MANUAL     = 2'd0,
        S_SWEEP_UP   = 2'd1,
        S_SWEEP_DOWN = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_angle;
    logic                r_upd;
    logic                r_dir;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [WIDTH:0]      w_up_sum;
    logic [WIDTH-1:0]    w_up_angle;
    logic [WIDTH-1:0]    w_dn_angle;
    logic                w_cw_only;
    logic                w_ccw_only;
    logic                w_tick;

    // One extra bit keeps the saturation compares free of wrap-around.
    assign w_up_sum   = {1'b0, r_angle} + c_STEP_X;
    assign w_up_angle = (w_up_sum >= c_MAX_X) ? c_MAX : w_up_sum[WIDTH-1:0];
    assign w_dn_angle = ({1'b0, r_angle} < c_DN_FLOOR) ? c_MIN : (r_angle - c_STEP);

    assign w_cw_only  = bus.cw  & ~bus.ccw;
    assign w_ccw_only = bus.ccw & ~bus.cw;
    assign w_tick     = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_MANUAL;
            r_angle <= c_RESET;
            r_upd   <= 1'b0;
            r_dir   <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_MANUAL: begin
                    r_cnt <= '0;
                    if (w_cw_only) begin
                        r_angle <= w_up_angle;
                        r_upd   <= (w_up_angle != r_angle);
                    end else if (w_ccw_only) begin
                        r_angle <= w_dn_angle;
                        r_upd   <= (w_dn_angle != r_angle);
                    end
                    // Direction is chosen from the angle before any same-cycle step.
                    if (bus.auto_en) begin
                        if (r_angle == c_MAX) begin
                            r_state <= S_SWEEP_DOWN;
                            r_dir   <= 1'b0;
                        end else begin
                            r_state <= S_SWEEP_UP;
                            r_dir   <= 1'b1;
                        end
                    end
                end

                S_SWEEP_UP: begin
                    if (!bus.auto_en) begin
                        r_state <= S_MANUAL;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        r_cnt   <= '0;
                        r_angle <= w_up_angle;
                        r_upd   <= (w_up_angle != r_angle);
                        if (w_up_angle == c_MAX) begin
                            r_state <= S_SWEEP_DOWN;
                            r_dir   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SWEEP_DOWN: begin
                    if (!bus.auto_en) begin
                        r_state <= S_MANUAL;
                        r_cnt   <= '0;
                    end else if (w_tick) begin
                        r_cnt   <= '0;
                        r_angle <= w_dn_angle;
                        r_upd   <= (w_dn_angle != r_angle);
                        if (w_dn_angle == c_MIN) begin
                            r_state <= S_SWEEP_UP;
                            r_dir   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_MANUAL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.angle     = r_angle;
    assign bus.angle_upd = r_upd;
    assign bus.sweep_dir = r_dir;
    assign bus.at_limit  = (r_angle == c_MIN) || (r_angle == c_MAX);

endmodule
`default_nettype wire

// File: tb/tb_encoder_angle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_angle_ctrl
// Brief    : Directed self-checking bench for encoder_angle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_angle_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // u1: defaults with a short sweep; u2: STEP=4; u3: small sweep window.
    encoder_angle_ctrl_if #(.WIDTH(8)) bus1 ();
    encoder_angle_ctrl_if #(.WIDTH(8)) bus2 ();
    encoder_angle_ctrl_if #(.WIDTH(8)) bus3 ();

    encoder_angle_ctrl #(.SWEEP_DIV(4)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );
    encoder_angle_ctrl #(.STEP(4), .SWEEP_DIV(4)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );
    encoder_angle_ctrl #(.MIN_ANGLE(0), .MAX_ANGLE(8), .STEP(3),
                         .RESET_ANGLE(6), .SWEEP_DIV(4)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave)
    );

    int exp_ang [5] = '{8, 5, 2, 0, 3};
    int exp_dir [5] = '{0, 0, 0, 1, 1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int prev;
        bus1.cw = 0; bus1.ccw = 0; bus1.auto_en = 0;
        bus2.cw = 0; bus2.ccw = 0; bus2.auto_en = 0;
        bus3.cw = 0; bus3.ccw = 0; bus3.auto_en = 0;

        // Reset with cw pulsing: reset wins
        reset = 1'b1;
        bus1.cw = 1;
        tick();
        bus1.cw = 0;
        tick();
        bus1.cw = 1;
        tick();
        reset = 1'b0;
        bus1.cw = 0;
        check_eq("rst_angle",    32'(bus1.angle), 90);
        check_eq("rst_upd",      32'(bus1.angle_upd), 0);
        check_eq("rst_dir",      32'(bus1.sweep_dir), 1);
        check_eq("rst_at_limit", 32'(bus1.at_limit), 0);
        check_eq("rst_angle_u2", 32'(bus2.angle), 90);
        check_eq("rst_angle_u3", 32'(bus3.angle), 6);

        // Manual stepping: 5 cw then 2 ccw
        for (int i = 0; i < 5; i++) begin
            bus1.cw = 1;
            tick();
            bus1.cw = 0;
            check_eq("cw_angle", 32'(bus1.angle), 32'(91 + i));
            check_eq("cw_upd",   32'(bus1.angle_upd), 1);
            tick();
            check_eq("cw_upd_off", 32'(bus1.angle_upd), 0);
        end
        for (int i = 0; i < 2; i++) begin
            bus1.ccw = 1;
            tick();
            bus1.ccw = 0;
            check_eq("ccw_angle", 32'(bus1.angle), 32'(94 - i));
            check_eq("ccw_upd",   32'(bus1.angle_upd), 1);
            tick();
            check_eq("ccw_upd_off", 32'(bus1.angle_upd), 0);
        end

        // Simultaneous cw+ccw: no change
        bus1.cw = 1; bus1.ccw = 1;
        tick();
        bus1.cw = 0; bus1.ccw = 0;
        check_eq("both_angle", 32'(bus1.angle), 93);
        check_eq("both_upd",   32'(bus1.angle_upd), 0);

        // Saturation with STEP=4
        e = 90;
        for (int i = 0; i < 50; i++) begin
            prev = e;
            e = (e + 4 > 180) ? 180 : e + 4;
            bus2.cw = 1;
            tick();
            bus2.cw = 0;
            check_eq("sat_up_angle", 32'(bus2.angle), 32'(e));
            check_eq("sat_up_upd",   32'(bus2.angle_upd), (e != prev) ? 1 : 0);
            tick();
        end
        check_eq("sat_max_limit", 32'(bus2.at_limit), 1);
        for (int i = 0; i < 50; i++) begin
            prev = e;
            e = (e < 4) ? 0 : e - 4;
            bus2.ccw = 1;
            tick();
            bus2.ccw = 0;
            check_eq("sat_dn_angle", 32'(bus2.angle), 32'(e));
            check_eq("sat_dn_upd",   32'(bus2.angle_upd), (e != prev) ? 1 : 0);
            tick();
        end
        check_eq("sat_min_angle", 32'(bus2.angle), 0);
        check_eq("sat_min_limit", 32'(bus2.at_limit), 1);

        // cw in the same cycle auto_en rises is still applied
        bus2.cw = 1; bus2.auto_en = 1;
        tick();
        bus2.cw = 0; bus2.auto_en = 0;
        check_eq("entry_cw_angle", 32'(bus2.angle), 4);
        check_eq("entry_cw_upd",   32'(bus2.angle_upd), 1);
        check_eq("entry_cw_dir",   32'(bus2.sweep_dir), 1);
        tick();

        // Sweep 6 -> 8 -> 5 -> 2 -> 0 -> 3 with cw noise ignored
        bus3.auto_en = 1;
        tick();
        check_eq("sw_entry_angle", 32'(bus3.angle), 6);
        check_eq("sw_entry_dir",   32'(bus3.sweep_dir), 1);
        prev = 6;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                bus3.cw = (j == 0);
                tick();
                check_eq("sw_hold_angle", 32'(bus3.angle), 32'(prev));
                check_eq("sw_hold_upd",   32'(bus3.angle_upd), 0);
            end
            bus3.cw = 0;
            tick();
            check_eq("sw_step_angle", 32'(bus3.angle), 32'(exp_ang[k]));
            check_eq("sw_step_upd",   32'(bus3.angle_upd), 1);
            check_eq("sw_step_dir",   32'(bus3.sweep_dir), 32'(exp_dir[k]));
            if (exp_ang[k] == 8 || exp_ang[k] == 0)
                check_eq("sw_at_limit", 32'(bus3.at_limit), 1);
            prev = exp_ang[k];
        end
        bus3.auto_en = 0;
        tick();
        check_eq("sw_exit_angle", 32'(bus3.angle), 3);

        // Mode exit mid-sweep on u1 (angle 93)
        bus1.auto_en = 1;
        tick();
        tick();
        tick();
        bus1.auto_en = 0;
        tick();
        check_eq("exit_hold_angle", 32'(bus1.angle), 93);
        check_eq("exit_hold_upd",   32'(bus1.angle_upd), 0);
        tick();
        check_eq("exit_no_step", 32'(bus1.angle), 93);
        bus1.cw = 1;
        tick();
        bus1.cw = 0;
        check_eq("exit_cw_angle", 32'(bus1.angle), 94);

        // Re-entry: first step exactly SWEEP_DIV cycles after entry
        bus1.auto_en = 1;
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("reentry_hold", 32'(bus1.angle), 94);
        end
        tick();
        check_eq("reentry_step", 32'(bus1.angle), 95);

        // Reset mid-sweep
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_angle", 32'(bus1.angle), 90);
        check_eq("midrst_dir",   32'(bus1.sweep_dir), 1);
        check_eq("midrst_upd",   32'(bus1.angle_upd), 0);
        // auto_en still high: one cycle to leave MANUAL, then a full tick period
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            check_eq("midrst_hold", 32'(bus1.angle), 90);
        end
        tick();
        check_eq("midrst_step", 32'(bus1.angle), 91);
        bus1.auto_en = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encoder_angle_ctrl.md
Name: encoder_angle_ctrl

Overview:
- Downstream stage of the quadrature encoder decoder. Consumes its one-cycle cw/ccw step pulses and maintains the radar's commanded pointing angle.
- Two operating modes:
  - Manual mode: each detent moves the angle by STEP, saturating at the limits.
  - Auto-sweep mode: the angle ramps back and forth between the limits at a fixed tick rate.
- Output angle feeds the servo PWM / display stages, with a one-cycle change strobe.

Parameters:
- WIDTH, 8: angle register width in bits.
- MIN_ANGLE, 0: lower angle limit, inclusive.
- MAX_ANGLE, 180: upper angle limit, inclusive. Must satisfy MIN_ANGLE < MAX_ANGLE < 2**WIDTH.
- STEP, 1: angle increment per cw/ccw pulse or per sweep tick. Must satisfy 1 <= STEP <= MAX_ANGLE-MIN_ANGLE.
- RESET_ANGLE, 90: angle value after reset. Must lie within [MIN_ANGLE, MAX_ANGLE].
- SWEEP_DIV, 500000: clk cycles per sweep tick (10 ms at 50 MHz). Must be >= 2.

Ports:
- clk  input  1  50 MHz system clock
- reset  input  1  synchronous, active-high reset
- cw  input  1  one-cycle clockwise step pulse from the encoder decoder
- ccw  input  1  one-cycle counter-clockwise step pulse from the encoder decoder
- auto_en  input  1  level; 1 = auto-sweep mode, 0 = manual mode
- angle  output  WIDTH  current commanded angle, registered
- angle_upd  output  1  one-cycle strobe, high in the first cycle a new angle value is visible
- sweep_dir  output  1  1 = sweeping up, 0 = sweeping down; holds last value in manual mode
- at_limit  output  1  high when angle == MIN_ANGLE or angle == MAX_ANGLE; decoded from the registered angle

Behaviour:
- Reset (synchronous, priority over everything else):
  - angle = RESET_ANGLE, state = MANUAL, sweep_dir = 1, angle_upd = 0, tick counter = 0.
  - Reset asserted mid-sweep aborts the sweep in the same edge.
- Arithmetic:
  - All add/subtract operations use WIDTH+1 bits so no intermediate wraps.
  - Up step: result = min(angle+STEP, MAX_ANGLE).
  - Down step: result = max(angle-STEP, MIN_ANGLE). Computed without signed underflow, e.g. compare angle < MIN_ANGLE+STEP.
  - Angle never wraps.
- State machine: MANUAL, SWEEP_UP, SWEEP_DOWN.
  - MANUAL -> SWEEP_UP when auto_en=1 and angle < MAX_ANGLE.
  - MANUAL -> SWEEP_DOWN when auto_en=1 and angle == MAX_ANGLE.
  - SWEEP_UP/SWEEP_DOWN -> MANUAL whenever auto_en=0. Checked every cycle; the angle holds its current value.
  - SWEEP_UP -> SWEEP_DOWN on the tick whose result equals MAX_ANGLE.
  - SWEEP_DOWN -> SWEEP_UP on the tick whose result equals MIN_ANGLE.
  - sweep_dir = 1 in SWEEP_UP and 0 in SWEEP_DOWN. It updates in the same edge as the state change.
- MANUAL mode:
  - cw=1, ccw=0: up step.
  - ccw=1, cw=0: down step.
  - cw=1 and ccw=1 in the same cycle: no change.
  - Latency: the new angle is visible on the clk edge that samples the pulse (1 cycle).
- Sweep modes:
  - cw/ccw are ignored.
  - The tick counter counts 0..SWEEP_DIV-1 and resets to 0 on every entry to a sweep state.
  - When the counter reaches SWEEP_DIV-1, the angle steps in the current direction. The first step therefore lands SWEEP_DIV cycles after entry.
  - The counter is held at 0 in MANUAL.
- angle_upd:
  - Asserted for exactly one cycle, coincident with a changed angle value.
  - Not asserted when a step saturates with no change (e.g. cw at MAX_ANGLE), nor on simultaneous cw+ccw.
- Mode switch in the same cycle as a cw pulse: the MANUAL-mode rule applies only if the state is MANUAL at that edge. Entering sweep takes one cycle, so a cw in the auto_en rising cycle is applied.
- at_limit is valid in all states, including during reset.

Test Plan:
- Reset: assert reset 2 cycles with cw pulsing -> angle=90, angle_upd=0, sweep_dir=1, at_limit=0 after release.
- Manual stepping: from 90, 5 cw pulses then 2 ccw pulses -> angle 91..95 then 94, 93. One angle_upd per pulse, each in the cycle after the pulse.
- Saturation: defaults with STEP=4. 50 cw pulses from 90 -> angle reaches 180 and stays; no angle_upd after reaching 180; at_limit=1. Then 50 ccw pulses -> angle 0, at_limit=1.
- Simultaneous/ignored inputs: cw=ccw=1 in one cycle -> angle unchanged, no angle_upd. In sweep mode, cw pulses do not alter the ramp.
- Sweep: SWEEP_DIV=4, MIN=0, MAX=8, STEP=3, angle=6, auto_en=1.
  - Angle sequence 6 -> 8 -> 5 -> 2 -> 0 -> 3, one step every 4 cycles.
  - sweep_dir flips on reaching 8 and on reaching 0.
- Mode exit and reset mid-sweep: drop auto_en mid-sweep -> angle holds, tick counter cleared, cw steps resume. Assert reset mid-sweep -> angle=90, state MANUAL next cycle.
